// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: square-wave pitch generator for the on-board buzzer.
// Takes the sequencer's note code and octave and produces a glitch-free
// square wave whose pitch only changes at half-period boundaries.
//
// Optional feature macro: BUZZER_VOLUME_EN (adds 2-bit PWM volume control).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       1 = play, 0 = forced rest
//   note_in      note code: 1..7 = do..si, 0 and 8..15 = rest (15 = end marker)
//   octave_in    0 = low, 1 = middle, 2/3 = high
//   volume       (BUZZER_VOLUME_EN only) duty gate, 3 = always on
//   buzzer       square wave to the buzzer pin
//   tone_active  1 while a tone is sounding
//   note_start   one-cycle pulse when a new pitch begins sounding
module buzzer_tone_gen #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned CNT_W  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
`ifdef BUZZER_VOLUME_EN
    input  logic [1:0] volume,
`endif
    output logic       buzzer,
    output logic       tone_active,
    output logic       note_start
);

    // Middle-octave half-period counts, folded at elaboration time
    localparam int unsigned HALF_C = CLK_HZ / (2 * 262);
    localparam int unsigned HALF_D = CLK_HZ / (2 * 294);
    localparam int unsigned HALF_E = CLK_HZ / (2 * 330);
    localparam int unsigned HALF_F = CLK_HZ / (2 * 349);
    localparam int unsigned HALF_G = CLK_HZ / (2 * 392);
    localparam int unsigned HALF_A = CLK_HZ / (2 * 440);
    localparam int unsigned HALF_B = CLK_HZ / (2 * 494);

    // Parameter sanity: shortest count must allow a counter compare, longest must fit
    if ((HALF_B >> 1) < 2) begin : g_chk_min_half
        $error("buzzer_tone_gen: high-B half-period count below 2");
    end
    if (((HALF_C * 2) >> CNT_W) != 0) begin : g_chk_max_half
        $error("buzzer_tone_gen: low-C half-period count exceeds CNT_W");
    end

    typedef enum logic {
        IDLE = 1'b0,
        TONE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [CNT_W-1:0]   cur_half_q, cur_half_d;
    logic               buzzer_sq_q, buzzer_sq_d;
    logic               note_start_q, note_start_d;
    logic               tone_active_q;
    logic [CNT_W-1:0]   mid_half_c;
    logic [CNT_W-1:0]   req_half_c;

    // Middle-octave count for the note code; rests map to 0
    always_comb begin
        mid_half_c = '0;
        case (note_in)
            4'd1:    mid_half_c = CNT_W'(HALF_C);
            4'd2:    mid_half_c = CNT_W'(HALF_D);
            4'd3:    mid_half_c = CNT_W'(HALF_E);
            4'd4:    mid_half_c = CNT_W'(HALF_F);
            4'd5:    mid_half_c = CNT_W'(HALF_G);
            4'd6:    mid_half_c = CNT_W'(HALF_A);
            4'd7:    mid_half_c = CNT_W'(HALF_B);
            default: mid_half_c = '0;
        endcase
    end

    // Requested half-period after octave scaling; 0 means silence
    always_comb begin
        req_half_c = '0;
        if (enable) begin
            case (octave_in)
                2'd0:    req_half_c = mid_half_c << 1;
                2'd1:    req_half_c = mid_half_c;
                default: req_half_c = mid_half_c >> 1;
            endcase
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        cur_half_d   = cur_half_q;
        buzzer_sq_d  = buzzer_sq_q;
        note_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                buzzer_sq_d = 1'b0;
                counter_d   = '0;
                if (req_half_c != '0) begin
                    cur_half_d   = req_half_c;
                    buzzer_sq_d  = 1'b1;
                    note_start_d = 1'b1;
                    state_d      = TONE;
                end
            end
            TONE: begin
                if (req_half_c == '0) begin
                    // Silence immediately, no boundary wait
                    buzzer_sq_d = 1'b0;
                    counter_d   = '0;
                    cur_half_d  = '0;
                    state_d     = IDLE;
                end else if (counter_q == cur_half_q - CNT_W'(1)) begin
                    // Half-period boundary: the only point a new pitch is adopted
                    counter_d    = '0;
                    buzzer_sq_d  = ~buzzer_sq_q;
                    cur_half_d   = req_half_c;
                    note_start_d = (req_half_c != cur_half_q);
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                buzzer_sq_d = 1'b0;
                counter_d   = '0;
                cur_half_d  = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            cur_half_q    <= '0;
            buzzer_sq_q   <= 1'b0;
            note_start_q  <= 1'b0;
            tone_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            cur_half_q    <= cur_half_d;
            buzzer_sq_q   <= buzzer_sq_d;
            note_start_q  <= note_start_d;
            tone_active_q <= (state_d == TONE);
        end
    end

`ifdef BUZZER_VOLUME_EN
    logic [1:0] pwm_cnt_q, pwm_cnt_d;
    logic       buzzer_q;

    assign pwm_cnt_d = pwm_cnt_q + 2'd1;

    // Volume gate: square wave ANDed with a free-running 4-step duty window
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= 2'd0;
            buzzer_q  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            buzzer_q  <= buzzer_sq_d & (pwm_cnt_d <= volume);
        end
    end

    assign buzzer = buzzer_q;
`else
    assign buzzer = buzzer_sq_q;
`endif

    assign tone_active = tone_active_q;
    assign note_start  = note_start_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Testbench for buzzer_tone_gen: directed scenarios plus randomized inputs,
// checked every cycle against a phase-level behavioural model.
module tb_buzzer_tone_gen;

    localparam int unsigned CLK_HZ = 52400;
    localparam int unsigned CNT_W  = 20;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       buzzer;
    logic       tone_active;
    logic       note_start;
`ifdef BUZZER_VOLUME_EN
    logic [1:0] volume;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    // Behavioural model: which tone is sounding, its level and phase progress
    bit m_play    = 0;
    bit m_level   = 0;
    bit m_ns      = 0;
    int m_len     = 0;
    int m_elapsed = 0;
    int m_pwm     = 0;
    bit exp_buz   = 0;

    buzzer_tone_gen #(
        .CLK_HZ(CLK_HZ),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .note_in    (note_in),
        .octave_in  (octave_in),
`ifdef BUZZER_VOLUME_EN
        .volume     (volume),
`endif
        .buzzer     (buzzer),
        .tone_active(tone_active),
        .note_start (note_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Half-period in cycles for a given input combination, straight from the pitch table
    function automatic int ref_half(input logic en, input logic [3:0] n, input logic [1:0] oct);
        int freq [7];
        int mid;
        freq = '{262, 294, 330, 349, 392, 440, 494};
        if (!en || n < 4'd1 || n > 4'd7) return 0;
        mid = int'(CLK_HZ) / (2 * freq[int'(n) - 1]);
        if (oct == 2'd0) return mid * 2;
        if (oct == 2'd1) return mid;
        return mid / 2;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cycle, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cycle, obs, exp);
        end
    endtask

    // Advance one clock, update the model with the inputs seen at the edge, check outputs
    task automatic step();
        int rq;
        @(posedge clk);
        cycle++;
        rq = ref_half(enable, note_in, octave_in);
        if (reset) begin
            m_play = 0; m_level = 0; m_ns = 0; m_len = 0; m_elapsed = 0; m_pwm = 0;
        end else begin
            m_pwm = (m_pwm + 1) % 4;
            m_ns  = 0;
            if (!m_play) begin
                if (rq != 0) begin
                    m_play = 1; m_level = 1; m_len = rq; m_elapsed = 1; m_ns = 1;
                end
            end else if (rq == 0) begin
                m_play = 0; m_level = 0; m_len = 0; m_elapsed = 0;
            end else if (m_elapsed == m_len) begin
                m_level   = ~m_level;
                m_ns      = (rq != m_len);
                m_len     = rq;
                m_elapsed = 1;
            end else begin
                m_elapsed++;
            end
        end
`ifdef BUZZER_VOLUME_EN
        exp_buz = m_level && (m_pwm <= int'(volume));
`else
        exp_buz = m_level;
`endif
        #1;
        chk_bit("buzzer", buzzer, exp_buz);
        chk_bit("tone_active", tone_active, m_play);
        chk_bit("note_start", note_start, m_ns);
    endtask

    // Length of the phase the buzzer is currently in, counting the current cycle
    task automatic phase_len(output int n);
        logic lv;
        lv = buzzer;
        n  = 1;
        while (n < 1000) begin
            step();
            if (buzzer !== lv) break;
            n++;
        end
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        note_in   = 4'd1;
        octave_in = 2'd1;
`ifdef BUZZER_VOLUME_EN
        volume    = 2'd3;
`endif

        // Reset held with a tone requested: silent
        repeat (3) begin
            step();
            chk_bit("rst_buzzer", buzzer, 1'b0);
            chk_bit("rst_tone_active", tone_active, 1'b0);
        end

        // Release: immediate rise with note_start, then 100/100 phases
        reset = 1'b0;
        step();
        chk_bit("start_buzzer", buzzer, 1'b1);
        chk_bit("start_pulse", note_start, 1'b1);
        phase_len(n); chk_int("midC_high", n, 100);
        phase_len(n); chk_int("midC_low", n, 100);

        // Pitch change 30 cycles into a high phase: old half completes first
        repeat (29) step();
        note_in = 4'd2;
        phase_len(n); chk_int("change_old_high", 29 + n, 100);
        chk_bit("change_pulse", note_start, 1'b1);
        phase_len(n); chk_int("midD_low", n, 89);
        phase_len(n); chk_int("midD_high", n, 89);

        // Octave scaling: low, high, and 3 aliasing high
        note_in = 4'd1; octave_in = 2'd0;
        phase_len(n); chk_int("midD_tail", n, 89);
        phase_len(n); chk_int("lowC_half", n, 200);
        octave_in = 2'd2;
        phase_len(n); chk_int("lowC_half2", n, 200);
        phase_len(n); chk_int("highC_half", n, 50);
        octave_in = 2'd3;
        phase_len(n); chk_int("highC_half2", n, 50);
        chk_bit("oct3_no_pulse", note_start, 1'b0);
        phase_len(n); chk_int("oct3_half", n, 50);

        // End marker silences immediately, restore restarts with a pulse
        octave_in = 2'd1;
        repeat (7) step();
        note_in = 4'd15;
        step();
        chk_bit("end_buzzer", buzzer, 1'b0);
        chk_bit("end_tone_active", tone_active, 1'b0);
        repeat (4) step();
        note_in = 4'd1;
        step();
        chk_bit("restore_buzzer", buzzer, 1'b1);
        chk_bit("restore_pulse", note_start, 1'b1);
        phase_len(n); chk_int("restore_high", n, 100);

        // enable low is a forced rest
        repeat (10) step();
        enable = 1'b0;
        step();
        chk_bit("dis_buzzer", buzzer, 1'b0);
        chk_bit("dis_tone_active", tone_active, 1'b0);
        repeat (3) step();
        enable = 1'b1;
        step();
        chk_bit("en_buzzer", buzzer, 1'b1);
        chk_bit("en_pulse", note_start, 1'b1);

        // Short rest inside a half-period: stop at once, restart freshly aligned
        repeat (4) step();
        note_in = 4'd0;
        step();
        chk_bit("glitch_silent", buzzer, 1'b0);
        repeat (4) step();
        note_in = 4'd1;
        step();
        chk_bit("glitch_restart", note_start, 1'b1);
        phase_len(n); chk_int("glitch_fresh_high", n, 100);

        // Reset mid-tone clears everything on the next cycle
        repeat (20) step();
        reset = 1'b1;
        step();
        chk_bit("midrst_buzzer", buzzer, 1'b0);
        chk_bit("midrst_tone_active", tone_active, 1'b0);
        reset = 1'b0;

        // Randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 1) == 0) note_in = 4'($urandom_range(1, 7));
                else                           note_in = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 119) == 0) octave_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;

`ifdef BUZZER_VOLUME_EN
        // Reduced volume gates the square wave with the PWM window
        enable = 1'b1; note_in = 4'd1; octave_in = 2'd1;
        volume = 2'd1;
        repeat (300) step();
        volume = 2'd3;
        repeat (50) step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_gen.md
Name: buzzer_tone_gen

Overview:
- Downstream stage of the auto-play sequencer. Consumes its note code (4-bit) and octave (2-bit) and drives the on-board buzzer pin with a square wave at the note's pitch.
- Sits between the sequencer and the top-level buzzer output.
- Pitch changes take effect only at half-period boundaries, so the waveform never glitches.
- Rest and end-of-song codes give silence.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; all half-period counts derive from it.
- CNT_W, 20, width of the half-period counter and period registers.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = play; 0 = forced rest
- note_in  input  4  note code: 1..7 = do..si; 0, 8..15 = rest (15 = end marker)
- octave_in  input  2  0 = low, 1 = middle, 2 = high, 3 = treated as high
- buzzer  output  1  square wave to buzzer
- tone_active  output  1  1 while in TONE state
- note_start  output  1  one-cycle pulse when a new pitch begins sounding

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: buzzer = 0, tone_active = 0, note_start = 0, counter = 0, cur_half = 0, state = IDLE.
- Middle-octave frequencies for notes 1..7: 262, 294, 330, 349, 392, 440, 494 Hz.
- Middle half-period count: mid = CLK_HZ / (2*f), integer division, constant-folded.
- Octave scaling: low = mid*2; high = mid>>1.
- req_half is combinational from the inputs. It is 0 when enable = 0 or note_in is outside 1..7; otherwise it is the scaled count.
- All counts must fit in CNT_W bits. High-B count must be >= 2 (parameter constraint, checked by assertion).
- State machine, two states:
  - IDLE: buzzer = 0, counter = 0. If req_half != 0: cur_half <= req_half, counter <= 0, buzzer <= 1, note_start <= 1, go to TONE. First buzzer rise is 1 cycle after the input becomes a tone.
  - TONE, if req_half == 0: next cycle buzzer = 0, counter = 0, cur_half = 0, go to IDLE (immediate silence, no boundary wait).
  - TONE, else if counter == cur_half-1: counter <= 0, buzzer toggles, cur_half <= req_half. If req_half != cur_half, note_start <= 1.
  - TONE, otherwise: counter increments.
- Waveform timing: each high and each low phase lasts exactly cur_half cycles, so the period is 2*cur_half cycles.
- Pitch change mid-half-period: the current half completes at the old count; the next half uses the new count. A change during a low phase behaves identically.
- Changes that come and go between boundaries are ignored; only the value present at the boundary cycle is taken.
- The same note repeated consecutively gives a continuous tone, with no retrigger and no note_start.
- note_start is 0 on every cycle except those specified above.
- tone_active = 1 exactly when state == TONE.
- enable deasserted mid-tone is treated as rest.
- Reset asserted mid-tone: buzzer = 0 on the next cycle, all state cleared.
- No arithmetic overflow: the counter compares only against cur_half-1, with cur_half >= 2 in TONE.

Optional Feature:
- Macro: BUZZER_VOLUME_EN.
- When defined:
  - Adds port volume input 2.
  - A free-running 2-bit pwm_cnt (reset 0) runs every cycle.
  - Output is buzzer_sq AND (pwm_cnt <= volume). volume = 3 means always on, i.e. identical to the non-macro output.
  - tone_active and note_start are unaffected.
- When undefined: no volume port, no pwm_cnt; buzzer is the pure square wave.

Test Plan:
- Bench uses CLK_HZ = 52400, giving middle C half = 100, middle D = 89, low C = 200, high C = 50.
- Reset held 3 cycles with note_in = 1, octave = 1 -> buzzer = 0, tone_active = 0 throughout. Release -> note_start pulses 1 cycle, buzzer high 100 cycles then low 100 cycles, repeating.
- Middle C playing; switch to note 2 at 30 cycles into a high phase -> high phase still 100 cycles. Next phases are 89 cycles each; single note_start at the boundary.
- octave_in 0 then 2 then 3 with note 1 -> half-periods 200, 50, 50. The 3-vs-2 transition produces no note_start.
- Tone playing; note_in = 15 (end marker) or enable = 0 -> buzzer = 0 and tone_active = 0 from the next cycle. Restore -> buzzer rises 1 cycle later with note_start.
- note_in 1 -> 0 -> 1 held only 5 cycles each inside one half-period -> tone stops immediately on 0. Restart yields fresh phase alignment: counter 0, buzzer high.
- BUZZER_VOLUME_EN defined, volume = 1, tone high phase -> buzzer pattern 1,1,0,0 repeating. With volume = 3 -> output identical to the non-macro build.
